// File: rtl/viexo_video_timing_if.sv
// Pixel-side bundle between the raster timing generator and its neighbours.
// The master (timing generator) drives the raster position request, the
// pixel strobe, and the encoder-facing de/c/d_* signals. The slave
// (upstream pixel source plus TMDS lanes) returns the requested pixel on rgb.
//   pix_stb      one-cycle pulse on the last aclk of each pixel period
//   req, x, y    pixel request for column x / row y
//   frame_start  high for the period requesting (0,0)
//   de, c        data enable and {vsync, hsync} for the lanes
//   d_r/d_g/d_b  registered pixel data for the lanes
//   rgb          pixel returned by upstream, {R, G, B}
interface viexo_video_timing_if;
  logic        pix_stb;
  logic        req;
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_start;
  logic        de;
  logic [1:0]  c;
  logic [7:0]  d_r;
  logic [7:0]  d_g;
  logic [7:0]  d_b;
  logic [23:0] rgb;

  modport master (
    output pix_stb, req, x, y, frame_start, de, c, d_r, d_g, d_b,
    input  rgb
  );

  modport slave (
    input  pix_stb, req, x, y, frame_start, de, c, d_r, d_g, d_b,
    output rgb
  );
endinterface

// File: rtl/viexo_video_timing.sv
// Video raster timing generator for the three viexo_tmds lanes.
// aclk is divided into pixel periods of DIV cycles; every pixel period the
// raster position advances, a pixel request for that position is issued
// (stage 1), and one period later the encoder-facing de/c/d_* are registered
// (stage 2). All outputs except pix_stb change only on pix_stb edges, so
// they stay constant for a full DIV-cycle TMDS symbol.
// Ports:
//   aclk     clock
//   aresetn  asynchronous active-low reset
//   enable   run the raster; low returns everything to reset values
//   vid      viexo_video_timing_if master modport (see interface header)
module viexo_video_timing #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int DIV       = 10
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  viexo_video_timing_if.master   vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [11:0]   H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0]   V_LAST   = 12'(V_TOTAL - 1);

  // Region bounds are 13 bits wide so an end bound of exactly 4096 still
  // compares correctly against the 12-bit counters.
  localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG    = 13'(H_ACTIVE + H_FRONT);
  localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG    = 13'(V_ACTIVE + V_FRONT);
  localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic [1:0]  C_IDLE    = {~VSYNC_POL, ~HSYNC_POL};

  logic [DW-1:0] div_cnt;
  logic [11:0]   hcnt;
  logic [11:0]   vcnt;
  logic          stb;

  // Stage 1: request for the position the counters held last period
  logic          req1;
  logic [11:0]   x1;
  logic [11:0]   y1;
  logic          hs1;
  logic          vs1;
  logic          fs1;

  // Stage 2: encoder-facing registers
  logic          de2;
  logic [1:0]    c2;
  logic [23:0]   d2;

  // Stage 1 next values, decoded from the current counters
  logic [12:0]   h13;
  logic [12:0]   v13;
  logic          req_n;
  logic          hs_n;
  logic          vs_n;
  logic          fs_n;

  assign stb = (div_cnt == DIV_LAST) && enable;

  always_comb begin
    h13   = {1'b0, hcnt};
    v13   = {1'b0, vcnt};
    req_n = (h13 < H_ACT_END) && (v13 < V_ACT_END);
    hs_n  = (h13 >= HS_BEG) && (h13 < HS_END);
    vs_n  = (v13 >= VS_BEG) && (v13 < VS_END);
    fs_n  = (hcnt == '0) && (vcnt == '0);
  end

  // Pixel-period divider
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_cnt <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Raster counters; the vertical counter steps on the horizontal wrap
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!enable) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (stb) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        if (vcnt == V_LAST) begin
          vcnt <= '0;
        end else begin
          vcnt <= vcnt + 1'b1;
        end
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Both pipeline stages load on the same strobe edge: stage 2 captures the
  // request stage 1 held during the period that is ending, together with
  // the pixel upstream returned for it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req1 <= 1'b0;
      x1   <= '0;
      y1   <= '0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      fs1  <= 1'b0;
      de2  <= 1'b0;
      c2   <= C_IDLE;
      d2   <= '0;
    end else if (!enable) begin
      req1 <= 1'b0;
      x1   <= '0;
      y1   <= '0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      fs1  <= 1'b0;
      de2  <= 1'b0;
      c2   <= C_IDLE;
      d2   <= '0;
    end else if (stb) begin
      req1 <= req_n;
      x1   <= req_n ? hcnt : '0;
      y1   <= req_n ? vcnt : '0;
      hs1  <= hs_n;
      vs1  <= vs_n;
      fs1  <= fs_n;
      de2  <= req1;
      c2   <= {vs1 ? VSYNC_POL : ~VSYNC_POL, hs1 ? HSYNC_POL : ~HSYNC_POL};
      d2   <= req1 ? vid.rgb : '0;
    end
  end

  assign vid.pix_stb     = stb;
  assign vid.req         = req1;
  assign vid.x           = x1;
  assign vid.y           = y1;
  assign vid.frame_start = fs1;
  assign vid.de          = de2;
  assign vid.c           = c2;
  assign vid.d_r         = d2[23:16];
  assign vid.d_g         = d2[15:8];
  assign vid.d_b         = d2[7:0];

endmodule

// File: tb/tb_viexo_video_timing.sv
// Self-checking bench for viexo_video_timing with a small 8x6 raster.
// Two instances share clock/reset/enable/rgb: one with default (active-low)
// sync polarities, one with both polarities set to 1.
module tb_viexo_video_timing;

  localparam int HA  = 4;
  localparam int HF  = 1;
  localparam int HS  = 2;
  localparam int HB  = 1;
  localparam int VA  = 3;
  localparam int VF  = 1;
  localparam int VS  = 1;
  localparam int VB  = 1;
  localparam int DIV = 10;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;

  typedef struct packed {
    logic        stb;
    logic        req;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        de;
    logic [1:0]  c;
    logic [23:0] d;
  } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b1;
  logic [23:0] rgb_drv = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  bit          pattern_mode = 1'b1;
  logic [23:0] pix_mem [VA][HA];

  exp_t        e0;
  exp_t        e1;
  logic        fs_prev = 1'b0;
  bit          have_fs = 1'b0;
  int unsigned last_fs_cyc = 0;

  viexo_video_timing_if vid0 ();
  viexo_video_timing_if vid1 ();

  assign vid0.rgb = rgb_drv;
  assign vid1.rgb = rgb_drv;

  viexo_video_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .DIV(DIV)
  ) dut0 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .vid(vid0)
  );

  viexo_video_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .DIV(DIV)
  ) dut1 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .vid(vid1)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d t=%0t", name, act, exp, cyc, $time);
    end
  endtask

  // Expected outputs after 'cy' running aclk edges. Pixel period k shows the
  // request for raster position k-1 and the lane data for position k-2.
  function automatic exp_t model(input int unsigned cy, input bit en, input bit hp, input bit vp);
    exp_t e;
    int unsigned k, pos, h, v;
    e = '0;
    e.c = {~vp, ~hp};
    k = cy / DIV;
    e.stb = en && ((cy % DIV) == DIV - 1);
    if (k >= 1) begin
      pos = (k - 1) % (HT * VT);
      h = pos % HT;
      v = pos / HT;
      e.req = (h < HA) && (v < VA);
      if (e.req) begin
        e.x = 12'(h);
        e.y = 12'(v);
      end
      e.fs = (pos == 0);
    end
    if (k >= 2) begin
      pos = (k - 2) % (HT * VT);
      h = pos % HT;
      v = pos / HT;
      e.de = (h < HA) && (v < VA);
      e.c[0] = (h >= HA + HF && h < HA + HF + HS) ? hp : ~hp;
      e.c[1] = (v >= VA + VF && v < VA + VF + VS) ? vp : ~vp;
      if (e.de) e.d = pix_mem[v][h];
    end
    return e;
  endfunction

  // Running-cycle count: restarts on reset or while enable is low
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cyc <= 0;
    else if (!enable) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Upstream pixel source: answers the current request shortly after the
  // strobe edge; returns noise when nothing is requested.
  always begin
    @(posedge aclk);
    #2;
    if (vid0.req && vid0.x < HA && vid0.y < VA)
      rgb_drv = pix_mem[vid0.y][vid0.x];
    else
      rgb_drv = 24'($urandom);
  end

  always @(negedge aclk) begin
    e0 = model(cyc, enable, 1'b0, 1'b0);
    e1 = model(cyc, enable, 1'b1, 1'b1);
    check("pix_stb",     vid0.pix_stb,     e0.stb);
    check("req",         vid0.req,         e0.req);
    check("x",           vid0.x,           e0.x);
    check("y",           vid0.y,           e0.y);
    check("frame_start", vid0.frame_start, e0.fs);
    check("de",          vid0.de,          e0.de);
    check("c",           vid0.c,           e0.c);
    check("d_r",         vid0.d_r,         e0.d[23:16]);
    check("d_g",         vid0.d_g,         e0.d[15:8]);
    check("d_b",         vid0.d_b,         e0.d[7:0]);
    check("c_pol1",      vid1.c,           e1.c);
    check("de_pol1",     vid1.de,          e0.de);
    if (pattern_mode && e0.de) check("d_b_pattern", vid0.d_b, 8'hA5);
    if (cyc == 0) have_fs = 1'b0;
    if (vid0.frame_start && !fs_prev) begin
      if (have_fs) check("frame_period", cyc - last_fs_cyc, 480);
      have_fs = 1'b1;
      last_fs_cyc = cyc;
    end
    fs_prev = vid0.frame_start;
  end

  task automatic fill_pattern();
    for (int v = 0; v < VA; v++)
      for (int h = 0; h < HA; h++)
        pix_mem[v][h] = {8'(h), 8'(v), 8'hA5};
  endtask

  task automatic fill_random();
    for (int v = 0; v < VA; v++)
      for (int h = 0; h < HA; h++)
        pix_mem[v][h] = 24'($urandom);
  endtask

  task automatic async_pulse();
    @(posedge aclk);
    #3 aresetn = 1'b0;
    #1;
    check("async_pix_stb", vid0.pix_stb, 1'b0);
    check("async_req",     vid0.req,     1'b0);
    check("async_x",       vid0.x,       12'd0);
    check("async_de",      vid0.de,      1'b0);
    check("async_d_r",     vid0.d_r,     8'd0);
    check("async_c",       vid0.c,       2'b11);
    check("async_c_pol1",  vid1.c,       2'b00);
    @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  // Literal timing after a start: strobe on the 9th cycle, (0,0) request
  // with frame_start once the 10th edge has passed.
  task automatic start_literals();
    for (int i = 1; i <= 9; i++) begin
      @(posedge aclk);
      #1;
      if (i < 9) check("stb_early", vid0.pix_stb, 1'b0);
      else       check("stb_first", vid0.pix_stb, 1'b1);
    end
    @(posedge aclk);
    #1;
    check("first_x",     vid0.x,           12'd0);
    check("first_y",     vid0.y,           12'd0);
    check("first_req",   vid0.req,         1'b1);
    check("first_fs",    vid0.frame_start, 1'b1);
    check("first_c",     vid0.c,           2'b11);
    check("first_cpol1", vid1.c,           2'b00);
    check("first_stb_off", vid0.pix_stb,   1'b0);
  endtask

  initial begin
    int unsigned act, n;
    fill_pattern();
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    start_literals();
    repeat (1500) @(posedge aclk);

    // Disable mid-line, then re-enable
    #1 enable = 1'b0;
    @(posedge aclk);
    #1;
    check("dis_x",   vid0.x,       12'd0);
    check("dis_de",  vid0.de,      1'b0);
    check("dis_c",   vid0.c,       2'b11);
    repeat (5) @(posedge aclk);
    #1 enable = 1'b1;
    start_literals();
    repeat (600) @(posedge aclk);

    // Async reset mid-frame, then same start sequence
    async_pulse();
    start_literals();
    repeat (300) @(posedge aclk);

    // Randomized phase with random pixel contents
    #1 enable = 1'b0;
    @(posedge aclk);
    pattern_mode = 1'b0;
    fill_random();
    #1 enable = 1'b1;
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(40, 1100)) @(posedge aclk);
      act = $urandom_range(0, 2);
      if (act == 0) begin
        #1 enable = 1'b0;
        n = $urandom_range(1, 25);
        repeat (n) @(posedge aclk);
        fill_random();
        #1 enable = 1'b1;
      end else if (act == 1) begin
        async_pulse();
      end
    end
    repeat (500) @(posedge aclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
